// File: rtl/ex_alu_muldiv.sv
// ex_alu_muldiv: execute stage of the MIPS-subset pipeline.
// Combinational ALU, HI/LO registers, an iterative shift-add multiplier
// (one bit per cycle) and the EX/MEM pipeline latch.
// Optional feature macro: EX_OVERFLOW_TRAP_EN enables signed overflow
// detection on ADD/ADDI/SUB. Without it, those behave like ADDU/ADDIU/SUBU.
module ex_alu_muldiv #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        wreg_en_in,
  input  logic [4:0]  wreg_addr_in,
  output logic        stall_req,
  output logic        valid_out,
  output logic [31:0] result,
  output logic        wreg_en,
  output logic [4:0]  wreg_addr,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        overflow
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [4:0] LAST_ITER = 5'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t  state;
  logic [4:0]  counter;
  logic [31:0] mcand;
  logic [63:0] prod;
  logic        neg;

  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] imm_zx;
  logic        add_ovf;
  logic        sub_ovf;
  logic [32:0] step;

  logic [31:0] alu_res;
  logic        defined;
  logic        is_mul;
  logic        mul_signed;
  logic        is_mthi;
  logic        is_mtlo;
  logic        ovf_det;
  logic        mul_start;
  logic        valid_next;

  assign sum    = operand_1 + operand_2;
  assign diff   = operand_1 - operand_2;
  assign imm_zx = {16'h0000, operand_2[15:0]};

`ifdef EX_OVERFLOW_TRAP_EN
  assign add_ovf = (operand_1[31] == operand_2[31]) && (sum[31] != operand_1[31]);
  assign sub_ovf = (operand_1[31] != operand_2[31]) && (diff[31] != operand_1[31]);
`else
  assign add_ovf = 1'b0;
  assign sub_ovf = 1'b0;
`endif

  // Upper 33 bits of the partial product after adding the multiplicand when the current multiplier bit is set.
  assign step = prod[0] ? ({1'b0, prod[63:32]} + {1'b0, mcand}) : {1'b0, prod[63:32]};

  // Decode op/funct into the ALU result and the side-effect flags for HI/LO and the multiplier.
  always_comb begin
    alu_res    = 32'd0;
    defined    = 1'b1;
    is_mul     = 1'b0;
    mul_signed = 1'b0;
    is_mthi    = 1'b0;
    is_mtlo    = 1'b0;
    ovf_det    = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_SLL:   alu_res = operand_2 << shamt;
          F_SRL:   alu_res = operand_2 >> shamt;
          F_SRA:   alu_res = $signed(operand_2) >>> shamt;
          F_JALR:  alu_res = operand_1;
          F_MFHI:  alu_res = hi;
          F_MTHI:  is_mthi = 1'b1;
          F_MFLO:  alu_res = lo;
          F_MTLO:  is_mtlo = 1'b1;
          F_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
          F_MULTU: is_mul = 1'b1;
          F_ADD:   begin alu_res = sum; ovf_det = add_ovf; end
          F_ADDU:  alu_res = sum;
          F_SUB:   begin alu_res = diff; ovf_det = sub_ovf; end
          F_SUBU:  alu_res = diff;
          F_AND:   alu_res = operand_1 & operand_2;
          F_OR:    alu_res = operand_1 | operand_2;
          F_XOR:   alu_res = operand_1 ^ operand_2;
          F_NOR:   alu_res = ~(operand_1 | operand_2);
          F_SLT:   alu_res = {31'd0, ($signed(operand_1) < $signed(operand_2))};
          F_SLTU:  alu_res = {31'd0, (operand_1 < operand_2)};
          default: defined = 1'b0;
        endcase
      end
      OP_JAL:   alu_res = operand_1;
      OP_ADDI:  begin alu_res = sum; ovf_det = add_ovf; end
      OP_ADDIU: alu_res = sum;
      OP_ANDI:  alu_res = operand_1 & imm_zx;
      OP_ORI:   alu_res = operand_1 | imm_zx;
      OP_LUI, OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW: alu_res = sum;
      default:  defined = 1'b0;
    endcase
  end

  assign mul_start  = valid_in && is_mul && !flush && (state == IDLE);
  assign stall_req  = !flush && (((state == IDLE) && valid_in && is_mul) || (state == BUSY));
  assign valid_next = valid_in && !flush && !stall_req;

  // EX/MEM latch: bubbles while the multiplier holds the pipe, write enable dropped on undefined ops, multiplies and overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      result    <= 32'd0;
      wreg_en   <= 1'b0;
      wreg_addr <= 5'd0;
    end else if (!stall_in) begin
      valid_out <= valid_next;
      result    <= alu_res;
      wreg_en   <= wreg_en_in && valid_next && defined && !is_mul && !ovf_det;
      wreg_addr <= wreg_addr_in;
    end
  end

`ifdef EX_OVERFLOW_TRAP_EN
  // Overflow flag travels with the instruction so the exception unit sees it alongside valid_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (!stall_in) begin
      overflow <= valid_next && ovf_det;
    end
  end
`else
  assign overflow = 1'b0;
`endif

  // Multiplier FSM and HI/LO: magnitudes multiplied by shift-add, sign applied when the product is written back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      counter <= 5'd0;
      mcand   <= 32'd0;
      prod    <= 64'd0;
      neg     <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (!stall_in) begin
      if (valid_next && is_mthi) hi <= operand_1;
      if (valid_next && is_mtlo) lo <= operand_1;
      case (state)
        IDLE: begin
          if (mul_start) begin
            mcand   <= (mul_signed && operand_1[31]) ? (~operand_1 + 32'd1) : operand_1;
            prod    <= {32'd0, (mul_signed && operand_2[31]) ? (~operand_2 + 32'd1) : operand_2};
            neg     <= mul_signed && (operand_1[31] ^ operand_2[31]);
            counter <= 5'd0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            counter <= 5'd0;
            state   <= IDLE;
          end else begin
            prod    <= {step, prod[31:1]};
            counter <= counter + 5'd1;
            if (counter == LAST_ITER) state <= DONE;
          end
        end
        DONE: begin
          if (!flush) {hi, lo} <= neg ? (~prod + 64'd1) : prod;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// tb_ex_alu_muldiv: directed and randomized bench for ex_alu_muldiv.
// A behavioural model (plain arithmetic, 64-bit products, occupancy count)
// is compared against the DUT on every falling clock edge.
`timescale 1ns/1ps
module tb_ex_alu_muldiv;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JALR = 6'h09;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        flush;
  logic        valid_in;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        wreg_en_in;
  logic [4:0]  wreg_addr_in;
  logic        stall_req;
  logic        valid_out;
  logic [31:0] result;
  logic        wreg_en;
  logic [4:0]  wreg_addr;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        overflow;

  always #5 clk = ~clk;

  ex_alu_muldiv dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .valid_in(valid_in),
    .op(op), .funct(funct), .shamt(shamt), .operand_1(operand_1), .operand_2(operand_2),
    .wreg_en_in(wreg_en_in), .wreg_addr_in(wreg_addr_in), .stall_req(stall_req),
    .valid_out(valid_out), .result(result), .wreg_en(wreg_en), .wreg_addr(wreg_addr),
    .hi(hi), .lo(lo), .overflow(overflow)
  );

  int   n_vectors = 0;
  int   n_checks = 0;
  int   n_miscompares = 0;
  logic last_sr;

  // Model state: what the EX/MEM latch and HI/LO must hold after the most recent rising edge.
  logic        m_valid, m_wen, m_ovf;
  logic [31:0] m_result, m_hi, m_lo;
  logic [4:0]  m_waddr;
  bit          m_busy;
  int          m_elapsed;
  logic [63:0] m_prod;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] o, input logic [5:0] f,
                               input logic [4:0] sa, input logic [31:0] a, input logic [31:0] b,
                               input logic we, input logic [4:0] wa, input logic fl, input logic si);
    valid_in = v; op = o; funct = f; shamt = sa; operand_1 = a; operand_2 = b;
    wreg_en_in = we; wreg_addr_in = wa; flush = fl; stall_in = si;
    #1 last_sr = stall_req;
    @(posedge clk);
    #1;
    n_vectors++;
  endtask

  // Behavioural ALU: what each instruction produces, written from the instruction semantics.
  function automatic void model_alu(input logic [5:0] o, input logic [5:0] f, input logic [4:0] sa,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] hv, input logic [31:0] lv,
                                    output logic [31:0] res, output bit def, output bit ovf,
                                    output bit mul, output bit mthi, output bit mtlo);
    longint s_add, s_sub;
    s_add = longint'($signed(a)) + longint'($signed(b));
    s_sub = longint'($signed(a)) - longint'($signed(b));
    res = 32'd0; def = 1; ovf = 0; mul = 0; mthi = 0; mtlo = 0;
    if (o == OP_SPECIAL) begin
      case (f)
        F_SLL:  res = 32'(b << sa);
        F_SRL:  res = b >> sa;
        F_SRA:  res = 32'(longint'($signed(b)) >>> sa);
        F_JALR: res = a;
        F_MFHI: res = hv;
        F_MFLO: res = lv;
        F_MTHI: mthi = 1;
        F_MTLO: mtlo = 1;
        F_MULT, F_MULTU: mul = 1;
        F_ADD:  begin res = 32'(s_add); ovf = (s_add > 64'sd2147483647) || (s_add < -64'sd2147483648); end
        F_ADDU: res = 32'(s_add);
        F_SUB:  begin res = 32'(s_sub); ovf = (s_sub > 64'sd2147483647) || (s_sub < -64'sd2147483648); end
        F_SUBU: res = 32'(s_sub);
        F_AND:  res = a & b;
        F_OR:   res = a | b;
        F_XOR:  res = a ^ b;
        F_NOR:  res = ~(a | b);
        F_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        F_SLTU: res = (a < b) ? 32'd1 : 32'd0;
        default: def = 0;
      endcase
    end else begin
      case (o)
        OP_JAL:  res = a;
        OP_ADDI: begin res = 32'(s_add); ovf = (s_add > 64'sd2147483647) || (s_add < -64'sd2147483648); end
        OP_ANDI: res = a & (b % 32'h10000);
        OP_ORI:  res = a | (b % 32'h10000);
        OP_ADDIU, OP_LUI, OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW: res = 32'(s_add);
        default: def = 0;
      endcase
    end
`ifndef EX_OVERFLOW_TRAP_EN
    ovf = 0;
`endif
  endfunction

  // Compare process: check DUT against the model, then advance the model across the coming rising edge.
  always @(negedge clk) begin
    logic [31:0] res;
    bit def, ovf, mul, mthi, mtlo, exp_sr, vn;
    if (rst) begin
      m_valid = 0; m_wen = 0; m_ovf = 0; m_result = 0; m_hi = 0; m_lo = 0; m_waddr = 0;
      m_busy = 0; m_elapsed = 0; m_prod = 0;
    end else begin
      checkOutput("valid_out", valid_out, m_valid);
      checkOutput("wreg_en", wreg_en, m_wen);
      checkOutput("overflow", overflow, m_ovf);
      checkOutput("hi", hi, m_hi);
      checkOutput("lo", lo, m_lo);
      if (m_valid) begin
        checkOutput("result", result, m_result);
        checkOutput("wreg_addr", wreg_addr, m_waddr);
      end
      model_alu(op, funct, shamt, operand_1, operand_2, m_hi, m_lo, res, def, ovf, mul, mthi, mtlo);
      if (flush)       exp_sr = 0;
      else if (m_busy) exp_sr = (m_elapsed < 33);
      else             exp_sr = valid_in && mul;
      checkOutput("stall_req", stall_req, exp_sr);
      if (!stall_in) begin
        vn = valid_in && !flush && !exp_sr;
        m_valid  = vn;
        m_result = res;
        m_waddr  = wreg_addr_in;
        m_wen    = wreg_en_in && vn && def && !mul && !ovf;
        m_ovf    = vn && ovf;
        if (vn && mthi) m_hi = operand_1;
        if (vn && mtlo) m_lo = operand_1;
        if (m_busy) begin
          if (flush) m_busy = 0;
          else if (m_elapsed == 33) begin
            {m_hi, m_lo} = m_prod;
            m_busy = 0;
          end else m_elapsed++;
        end else if (valid_in && mul && !flush) begin
          m_busy = 1;
          m_elapsed = 1;
          if (funct == F_MULT) m_prod = 64'(longint'($signed(operand_1)) * longint'($signed(operand_2)));
          else                 m_prod = {32'd0, operand_1} * {32'd0, operand_2};
        end
      end
    end
  end

  // Hold a multiply on the inputs until it retires (stall_req low with no outside stall) or is flushed.
  task automatic runMul(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int stall_at, input int stall_len,
                        output int cycles, output int stalled, output logic sr_at_flush);
    bit done;
    logic fl, si;
    cycles = 0; stalled = 0; sr_at_flush = 1'b1; done = 0;
    while (!done && cycles < 200) begin
      fl = (cycles == flush_at);
      si = (cycles >= stall_at) && (cycles < stall_at + stall_len);
      applyStimulus(1'b1, OP_SPECIAL, fn, 5'd0, a, b, 1'b0, 5'd0, fl, si);
      cycles++;
      if (last_sr) stalled++;
      if (fl) begin sr_at_flush = last_sr; done = 1; end
      else if (!last_sr && !si) done = 1;
    end
    checkOutput("mul_bound", 64'(done), 64'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [11:0] insn_tab [0:31] = '{
    {OP_SPECIAL, F_SLL}, {OP_SPECIAL, F_SRL}, {OP_SPECIAL, F_SRA}, {OP_SPECIAL, F_JALR},
    {OP_SPECIAL, F_MFHI}, {OP_SPECIAL, F_MTHI}, {OP_SPECIAL, F_MFLO}, {OP_SPECIAL, F_MTLO},
    {OP_SPECIAL, F_MULT}, {OP_SPECIAL, F_MULTU}, {OP_SPECIAL, F_ADD}, {OP_SPECIAL, F_ADDU},
    {OP_SPECIAL, F_SUB}, {OP_SPECIAL, F_SUBU}, {OP_SPECIAL, F_AND}, {OP_SPECIAL, F_OR},
    {OP_SPECIAL, F_XOR}, {OP_SPECIAL, F_NOR}, {OP_SPECIAL, F_SLT}, {OP_SPECIAL, F_SLTU},
    {OP_JAL, 6'h00}, {OP_ADDI, 6'h00}, {OP_ADDIU, 6'h00}, {OP_ANDI, 6'h00},
    {OP_ORI, 6'h00}, {OP_LUI, 6'h00}, {OP_LB, 6'h00}, {OP_LW, 6'h00},
    {OP_LBU, 6'h00}, {OP_SB, 6'h00}, {OP_SW, 6'h00}, {OP_SPECIAL, 6'h3F}
  };

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, stl;
    logic srf;
    logic cv, cwe, fl, si, need_new;
    logic [5:0] cop, cfn;
    logic [4:0] csa, cwa;
    logic [31:0] ca, cb;
    logic [11:0] ent;

    rst = 1'b1; stall_in = 0; flush = 0; valid_in = 0; op = 0; funct = 0; shamt = 0;
    operand_1 = 0; operand_2 = 0; wreg_en_in = 0; wreg_addr_in = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_valid", valid_out, 1'b0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_stall_req", stall_req, 1'b0);

    // ADDU at the signed boundary.
    applyStimulus(1, OP_SPECIAL, F_ADDU, 0, 32'h7FFF_FFFF, 32'h1, 1, 5'd5, 0, 0);
    checkOutput("addu_result", result, 32'h8000_0000);
    checkOutput("addu_wreg_en", wreg_en, 1'b1);
    checkOutput("addu_wreg_addr", wreg_addr, 5'd5);
    checkOutput("addu_overflow", overflow, 1'b0);

    // ADD with the same operands: trap when enabled, identical to ADDU otherwise.
    applyStimulus(1, OP_SPECIAL, F_ADD, 0, 32'h7FFF_FFFF, 32'h1, 1, 5'd5, 0, 0);
    checkOutput("add_valid", valid_out, 1'b1);
`ifdef EX_OVERFLOW_TRAP_EN
    checkOutput("add_overflow", overflow, 1'b1);
    checkOutput("add_wreg_en", wreg_en, 1'b0);
`else
    checkOutput("add_overflow", overflow, 1'b0);
    checkOutput("add_wreg_en", wreg_en, 1'b1);
    checkOutput("add_result", result, 32'h8000_0000);
`endif

    applyStimulus(1, OP_SPECIAL, F_SRA, 5'd4, 32'h0, 32'hF000_0000, 1, 5'd7, 0, 0);
    checkOutput("sra_result", result, 32'hFF00_0000);
    applyStimulus(1, OP_SPECIAL, F_SLTU, 0, 32'h1, 32'hFFFF_FFFF, 1, 5'd8, 0, 0);
    checkOutput("sltu_result", result, 32'h1);
    applyStimulus(1, OP_SPECIAL, F_SLT, 0, 32'h1, 32'hFFFF_FFFF, 1, 5'd9, 0, 0);
    checkOutput("slt_result", result, 32'h0);
    applyStimulus(1, OP_ORI, 6'h00, 0, 32'h0000_00F0, 32'hFFFF_0F0F, 1, 5'd10, 0, 0);
    checkOutput("ori_result", result, 32'h0000_0FFF);

    // MULT -3 * 7.
    runMul(F_MULT, 32'hFFFF_FFFD, 32'd7, -1, -1, 0, cyc, stl, srf);
    checkOutput("mult_cycles", 64'(cyc), 64'd34);
    checkOutput("mult_stalled", 64'(stl), 64'd33);
    checkOutput("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    applyStimulus(1, OP_SPECIAL, F_MFLO, 0, 32'h0, 32'h0, 1, 5'd3, 0, 0);
    checkOutput("mflo_result", result, 32'hFFFF_FFEB);

    applyStimulus(1, OP_SPECIAL, F_MTHI, 0, 32'h0000_1234, 32'h0, 0, 5'd0, 0, 0);
    applyStimulus(1, OP_SPECIAL, F_MFHI, 0, 32'h0, 32'h0, 1, 5'd4, 0, 0);
    checkOutput("mfhi_result", result, 32'h0000_1234);

    // MULTU flushed mid-flight, then re-issued.
    runMul(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, -1, 0, cyc, stl, srf);
    checkOutput("flush_stall_req", srf, 1'b0);
    checkOutput("flush_hilo_kept", {hi, lo}, 64'h0000_1234_FFFF_FFEB);
    runMul(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 0, cyc, stl, srf);
    checkOutput("multu_cycles", 64'(cyc), 64'd34);
    checkOutput("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // MULT of the most negative values with a 5-cycle outside stall.
    runMul(F_MULT, 32'h8000_0000, 32'h8000_0000, -1, 5, 5, cyc, stl, srf);
    checkOutput("stalled_mult_cycles", 64'(cyc), 64'd39);
    checkOutput("stalled_mult_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

    // Randomized traffic; an instruction stays on the inputs while the stage is stalled.
    need_new = 1;
    cv = 0; cop = 0; cfn = 0; csa = 0; ca = 0; cb = 0; cwe = 0; cwa = 0;
    for (int i = 0; i < 1500; i++) begin
      if (need_new) begin
        ent = insn_tab[$urandom_range(0, 31)];
        cop = ent[11:6];
        cfn = (cop == OP_SPECIAL) ? ent[5:0] : 6'($urandom);
        if ($urandom_range(0, 29) == 0) cop = 6'b000010;
        cv  = ($urandom_range(0, 9) != 0);
        csa = 5'($urandom);
        ca  = rand_operand();
        cb  = rand_operand();
        cwe = 1'($urandom);
        cwa = 5'($urandom);
      end
      fl = ($urandom_range(0, 39) == 0);
      si = ($urandom_range(0, 9) == 0);
      applyStimulus(cv, cop, cfn, csa, ca, cb, cwe, cwa, fl, si);
      need_new = (fl && !si) || (!last_sr && !si);
    end

    repeat (3) applyStimulus(0, 6'h0, 6'h0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
